serial_subtractor_16: RTL and testbench

Bit-serial two's-complement subtractor that computes diff = a - b, one bit per clock, LSB first. It uses the same status-flag set as the combinational 16-bit adder (sign, parity, overflow), plus borrow and zero. It is the area-lean inverse companion to that adder, for datapaths where a 17-cycle latency is acceptable. A start/busy/done handshake fronts it so a controller FSM can issue back-to-back operations.

---
 rtl/sub_pkg.sv | 11 +
 rtl/full_subtractor_1.sv | 13 +
 rtl/serial_subtractor_16.sv | 119 +++++++++++
 tb/tb_serial_subtractor_16.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants and state encoding for the serial subtractor
package sub_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/full_subtractor_1.sv
// rtl/full_subtractor_1.sv - combinational one-bit full subtractor cell
module full_subtractor_1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_16.sv
// rtl/serial_subtractor_16.sv - bit-serial a - b, LSB first, with borrow/sign/parity/overflow/zero flags
module serial_subtractor_16
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             sign,
   output logic             parity,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] res_sr;
   logic [CW-1:0]    cnt;
   logic             borrow_r;
   logic             a_msb, b_msb;
   logic             load, step, last;
   logic             d_bit, bout_bit;
   logic [WIDTH-1:0] final_diff;

   full_subtractor_1 u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow_r),
      .d    (d_bit),
      .bout (bout_bit)
   );

   // The last result bit is still in flight on the final edge, so splice it in here.
   assign final_diff = {d_bit, res_sr};
   assign busy       = (state == ST_SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            step = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last       = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         cnt      <= '0;
         borrow_r <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         borrow   <= 1'b0;
         sign     <= 1'b0;
         parity   <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            a_sr     <= a;
            b_sr     <= b;
            res_sr   <= '0;
            cnt      <= '0;
            borrow_r <= 1'b0;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
         end else if (step) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            res_sr   <= {d_bit, res_sr[WIDTH-2:1]};
            borrow_r <= bout_bit;
            cnt      <= cnt + CW'(1);
         end
         if (last) begin
            done     <= 1'b1;
            diff     <= final_diff;
            borrow   <= bout_bit;
            sign     <= final_diff[WIDTH-1];
            parity   <= ^final_diff;
            overflow <= (a_msb != b_msb) && (final_diff[WIDTH-1] != a_msb);
            zero     <= (final_diff == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor_16.sv
// tb/tb_serial_subtractor_16.sv - self-checking bench for serial_subtractor_16
module tb_serial_subtractor_16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        busy, done, borrow, sign, parity, overflow, zero;
   logic [15:0] diff;
   logic [20:0] obs;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   serial_subtractor_16 dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .borrow   (borrow),
      .sign     (sign),
      .parity   (parity),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   assign obs = {diff, borrow, sign, parity, overflow, zero};

   always @(posedge clk) begin
      #2;
      if (done === 1'b1) done_cnt++;
   end

   // Expected {diff, borrow, sign, parity, overflow, zero} from plain integer arithmetic.
   function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] d;
      int          sd;
      logic        ov;
      d  = x - y;
      sd = int'($signed(x)) - int'($signed(y));
      ov = (sd > 32767) || (sd < -32768);
      return {d, (x < y), (d >= 16'h8000), ($countones(d) % 2 == 1), ov, (d == 16'h0000)};
   endfunction

   task automatic issue(input logic [15:0] x, input logic [15:0] y);
      start = 1'b1;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 21'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", obs, 21'h0);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed;
      logic [15:0] va [3] = '{16'h0005, 16'h0000, 16'h8000};
      logic [15:0] vb [3] = '{16'h0003, 16'h0001, 16'h0001};
      logic [15:0] vd [3] = '{16'h0002, 16'hFFFF, 16'h7FFF};
      int n;
      for (int i = 0; i < 3; i++) begin
         issue(va[i], vb[i]);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL directed_busy[%0d]: got %b want 1", i, busy);
         end
         wait_done(n);
         checks++;
         if (n != 16) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d want 16", i, n);
         end
         checks++;
         if (diff !== vd[i]) begin
            errors++;
            $display("FAIL directed_diff[%0d]: got %h want %h", i, diff, vd[i]);
         end
         checks++;
         if (obs !== model(va[i], vb[i])) begin
            errors++;
            $display("FAIL directed_flags[%0d]: got %h want %h", i, obs, model(va[i], vb[i]));
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL directed_pulse[%0d]: got done=%b busy=%b want 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_back_to_back;
      int n, m;
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h1234;
      @(negedge clk);
      a = 16'h5678;
      b = 16'h1234;
      wait_done(n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL b2b_latency1: got %0d want 16", n);
      end
      checks++;
      if (obs !== model(16'h1234, 16'h1234)) begin
         errors++;
         $display("FAIL b2b_result1: got %h want %h", obs, model(16'h1234, 16'h1234));
      end
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept_in_done: got busy=%b want 1", busy);
      end
      wait_done(m);
      checks++;
      if (m + 1 != 17) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d want 17", m + 1);
      end
      checks++;
      if (obs !== model(16'h5678, 16'h1234)) begin
         errors++;
         $display("FAIL b2b_result2: got %h want %h", obs, model(16'h5678, 16'h1234));
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_third: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_ignore_start;
      int base, n;
      base = done_cnt;
      issue(16'h0010, 16'h0001);
      repeat (4) @(negedge clk);
      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      checks++;
      if (n + 5 != 16) begin
         errors++;
         $display("FAIL ignore_latency: got %0d want 16", n + 5);
      end
      checks++;
      if (obs !== model(16'h0010, 16'h0001)) begin
         errors++;
         $display("FAIL ignore_result: got %h want %h", obs, model(16'h0010, 16'h0001));
      end
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt - base != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_single_done: got %0d pulses busy=%b want 1 pulse busy=0", done_cnt - base, busy);
      end
   endtask

   task automatic test_reset_mid;
      int base, n;
      base = done_cnt;
      issue(16'hABCD, 16'hEF01);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 21'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: got %h busy=%b want 0 busy=0", obs, busy);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt != base || busy !== 1'b0 || obs !== 21'h0) begin
         errors++;
         $display("FAIL midreset_no_done: got pulses=%0d busy=%b out=%h want 0 0 0", done_cnt - base, busy, obs);
      end
      issue(16'h0001, 16'h0001);
      wait_done(n);
      checks++;
      if (n != 16 || obs !== model(16'h0001, 16'h0001) || zero !== 1'b1) begin
         errors++;
         $display("FAIL midreset_recover: got lat=%0d out=%h want lat=16 out=%h", n, obs, model(16'h0001, 16'h0001));
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [15:0] x, y;
      int n;
      for (int i = 0; i < 24; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         if (i % 6 == 0) y = x;
         if (i % 6 == 1) x = 16'h8000 | 16'($urandom_range(0, 15));
         issue(x, y);
         wait_done(n);
         checks++;
         if (n != 16 || obs !== model(x, y)) begin
            errors++;
            $display("FAIL random[%0d] %h-%h: got lat=%0d out=%h want lat=16 out=%h", i, x, y, n, obs, model(x, y));
         end
         if (i % 2 == 0) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
